// File: rtl/fetch_datapath_if.sv
// Fetch datapath bundle: control strobes, W-bus, programming port and status.
// master = sequencer/bench side, slave = fetch_datapath.
interface fetch_datapath_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    // control strobes from control_Unit
    logic          cp;
    logic          ep;
    logic          lm;
    logic          ce;
    logic          li;
    logic          ei;
    // W-bus
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out;
    logic          bus_drv;
    // programming port
    logic          prog_mode;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    // architectural state / status
    logic [3:0]    ireg;
    logic [AW-1:0] pc;
    logic [AW-1:0] mar;
    logic          halt;
    logic          bus_err;

    modport master (
        output cp, ep, lm, ce, li, ei, bus_in,
        output prog_mode, prog_we, prog_addr, prog_data,
        input  bus_out, bus_drv, ireg, pc, mar, halt, bus_err
    );

    modport slave (
        input  cp, ep, lm, ce, li, ei, bus_in,
        input  prog_mode, prog_we, prog_addr, prog_data,
        output bus_out, bus_drv, ireg, pc, mar, halt, bus_err
    );
endinterface

// File: rtl/fetch_datapath.sv
// Fetch-side datapath: PC, MAR, program RAM and IR around the shared W-bus.
// Executes the control_Unit strobes, returns the opcode nibble, and offers a
// RAM programming port that is only honoured while the CPU is held in prog_mode.
module fetch_datapath #(
    parameter int         AW     = 4,
    parameter int         DW     = 8,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic             clk,
    input  logic             clr,
    fetch_datapath_if.slave  io
);
    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] pc;
    logic [AW-1:0] mar;
    logic [DW-1:0] ir;
    logic          halt;
    logic          bus_err;
    logic [DW-1:0] mem [DEPTH];

    logic          run;
    logic          drv;
    logic [DW-1:0] drv_val;
    logic [DW-1:0] bus_val;
    logic          multi_drv;

    // Strobes only act when neither programming nor halted.
    assign run       = ~io.prog_mode & ~halt;
    assign drv       = run & (io.ep | io.ce | io.ei);
    assign multi_drv = (io.ep & io.ce) | (io.ep & io.ei) | (io.ce & io.ei);

    // Internal bus driver mux, priority ce > ei > ep; zero when not driving.
    always_comb begin
        drv_val = '0;
        if (drv) begin
            if (io.ce)
                drv_val = mem[mar];
            else if (io.ei)
                drv_val = DW'(ir[AW-1:0]);
            else
                drv_val = DW'(pc);
        end
    end

    // Loads see our own value when we drive, otherwise the external bus.
    assign bus_val = drv ? drv_val : io.bus_in;

    // PC / MAR / IR / status registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc      <= '0;
            mar     <= '0;
            ir      <= '0;
            halt    <= 1'b0;
            bus_err <= 1'b0;
        end else if (io.prog_mode) begin
            // programming parks the CPU at address 0; bus_err survives
            pc   <= '0;
            mar  <= '0;
            ir   <= '0;
            halt <= 1'b0;
        end else if (run) begin
            if (io.cp)
                pc <= pc + 1'b1;
            if (io.lm)
                mar <= bus_val[AW-1:0];
            if (io.li)
                ir <= bus_val;
            // halt reacts to the IR contents already latched, one cycle after li
            if (ir[DW-1:DW-4] == HLT_OP)
                halt <= 1'b1;
            if (multi_drv)
                bus_err <= 1'b1;
        end
    end

    // Program RAM write port; contents are not cleared and writes are
    // suppressed while clr is asserted.
    always_ff @(posedge clk) begin
        if (clr && io.prog_mode && io.prog_we)
            mem[io.prog_addr] <= io.prog_data;
    end

    assign io.bus_out = drv_val;
    assign io.bus_drv = drv;
    assign io.ireg    = ir[DW-1:DW-4];
    assign io.pc      = pc;
    assign io.mar     = mar;
    assign io.halt    = halt;
    assign io.bus_err = bus_err;
endmodule

// File: tb/tb_fetch_datapath.sv
// Bench for fetch_datapath: directed scenarios plus randomized strobes checked
// against a cycle-level model of the PC/MAR/IR/RAM machine.
module tb_fetch_datapath;
    logic clk = 1'b0;
    logic clr;
    int   vectors = 0;
    int   miscompares = 0;

    fetch_datapath_if #(.AW(4), .DW(8)) ifc ();

    fetch_datapath #(.AW(4), .DW(8), .HLT_OP(4'hF)) dut (
        .clk (clk),
        .clr (clr),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] m_mem [16];
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir;
    logic       m_halt, m_err;

    task automatic idle();
        ifc.cp = 0; ifc.ep = 0; ifc.lm = 0; ifc.ce = 0; ifc.li = 0; ifc.ei = 0;
        ifc.bus_in = 8'h00; ifc.prog_mode = 0; ifc.prog_we = 0;
        ifc.prog_addr = 4'h0; ifc.prog_data = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        idle();
        ifc.prog_mode = 1; ifc.prog_we = 1; ifc.prog_addr = a; ifc.prog_data = d;
        tick();
        m_mem[a] = d;
        idle();
    endtask

    task automatic hard_reset();
        idle();
        clr = 0;
        #2;
        clr = 1;
        m_pc = 0; m_mar = 0; m_ir = 0; m_halt = 0; m_err = 0;
    endtask

    task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
        idle();
        ifc.bus_in = {4'h0, a}; ifc.lm = 1;
        tick();
        idle();
        ifc.ce = 1;
        #1;
        d = ifc.bus_out;
        idle();
    endtask

    task automatic test_reset();
        idle();
        clr = 0;
        #1;
        vectors++; if ({ifc.pc, ifc.mar, ifc.ireg} !== 12'h000) begin miscompares++; $display("FAIL reset_regs got=%h exp=000", {ifc.pc, ifc.mar, ifc.ireg}); end
        vectors++; if ({ifc.halt, ifc.bus_err, ifc.bus_drv, ifc.bus_out} !== 11'h000) begin miscompares++; $display("FAIL reset_status got=%h exp=000", {ifc.halt, ifc.bus_err, ifc.bus_drv, ifc.bus_out}); end
        #11;
        clr = 1;
    endtask

    task automatic test_fetch();
        hard_reset();
        prog_write(4'h0, 8'h09);
        prog_write(4'h9, 8'h5A);
        // T1
        ifc.ep = 1; ifc.lm = 1;
        #1;
        vectors++; if ({ifc.bus_drv, ifc.bus_out} !== 9'h100) begin miscompares++; $display("FAIL fetch_t1_bus got=%h exp=100", {ifc.bus_drv, ifc.bus_out}); end
        tick();
        vectors++; if (ifc.mar !== 4'h0) begin miscompares++; $display("FAIL fetch_t1_mar got=%h exp=0", ifc.mar); end
        // T2
        idle(); ifc.cp = 1;
        tick();
        vectors++; if (ifc.pc !== 4'h1) begin miscompares++; $display("FAIL fetch_t2_pc got=%h exp=1", ifc.pc); end
        // T3
        idle(); ifc.ce = 1; ifc.li = 1;
        #1;
        vectors++; if (ifc.bus_out !== 8'h09) begin miscompares++; $display("FAIL fetch_t3_bus got=%h exp=09", ifc.bus_out); end
        tick();
        vectors++; if (ifc.ireg !== 4'h0) begin miscompares++; $display("FAIL fetch_t3_ireg got=%h exp=0", ifc.ireg); end
        // T4
        idle(); ifc.ei = 1; ifc.lm = 1;
        #1;
        vectors++; if (ifc.bus_out !== 8'h09) begin miscompares++; $display("FAIL fetch_t4_bus got=%h exp=09", ifc.bus_out); end
        tick();
        vectors++; if (ifc.mar !== 4'h9) begin miscompares++; $display("FAIL fetch_t4_mar got=%h exp=9", ifc.mar); end
        // T5
        idle(); ifc.ce = 1;
        #1;
        vectors++; if ({ifc.bus_drv, ifc.bus_out} !== 9'h15A) begin miscompares++; $display("FAIL fetch_t5_bus got=%h exp=15a", {ifc.bus_drv, ifc.bus_out}); end
        tick();
        vectors++; if (ifc.halt !== 1'b0) begin miscompares++; $display("FAIL fetch_no_halt got=%b exp=0", ifc.halt); end
        idle();
    endtask

    task automatic test_pc_wrap();
        hard_reset();
        for (int i = 1; i <= 17; i++) begin
            ifc.cp = 1;
            tick();
            if (i == 15) begin
                vectors++; if (ifc.pc !== 4'hF) begin miscompares++; $display("FAIL wrap_pc15 got=%h exp=f", ifc.pc); end
            end
            if (i == 16) begin
                vectors++; if (ifc.pc !== 4'h0) begin miscompares++; $display("FAIL wrap_pc16 got=%h exp=0", ifc.pc); end
            end
        end
        vectors++; if (ifc.pc !== 4'h1) begin miscompares++; $display("FAIL wrap_pc17 got=%h exp=1", ifc.pc); end
        idle();
    endtask

    task automatic test_halt();
        hard_reset();
        prog_write(4'h0, 8'hF0);
        ifc.ep = 1; ifc.lm = 1; tick();
        idle(); ifc.cp = 1; tick();
        idle(); ifc.ce = 1; ifc.li = 1; tick();
        vectors++; if ({ifc.ireg, ifc.halt} !== 5'b1111_0) begin miscompares++; $display("FAIL halt_ir_load got=%b exp=11110", {ifc.ireg, ifc.halt}); end
        idle(); tick();
        vectors++; if (ifc.halt !== 1'b1) begin miscompares++; $display("FAIL halt_set got=%b exp=1", ifc.halt); end
        ifc.cp = 1; ifc.li = 1; ifc.ep = 1; ifc.bus_in = 8'h11;
        #1;
        vectors++; if ({ifc.bus_drv, ifc.bus_out} !== 9'h000) begin miscompares++; $display("FAIL halt_bus got=%h exp=000", {ifc.bus_drv, ifc.bus_out}); end
        tick();
        vectors++; if ({ifc.pc, ifc.ireg} !== 8'h1F) begin miscompares++; $display("FAIL halt_frozen got=%h exp=1f", {ifc.pc, ifc.ireg}); end
        idle(); ifc.prog_mode = 1; tick();
        vectors++; if ({ifc.halt, ifc.pc} !== 5'h00) begin miscompares++; $display("FAIL halt_prog_clear got=%h exp=00", {ifc.halt, ifc.pc}); end
        idle();
    endtask

    task automatic test_bus_err();
        hard_reset();
        prog_write(4'h3, 8'hC4);
        ifc.bus_in = 8'h03; ifc.lm = 1; tick();
        vectors++; if (ifc.mar !== 4'h3) begin miscompares++; $display("FAIL err_mar got=%h exp=3", ifc.mar); end
        idle(); ifc.ep = 1; ifc.ce = 1;
        #1;
        vectors++; if ({ifc.bus_drv, ifc.bus_out, ifc.bus_err} !== 10'b1_1100_0100_0) begin miscompares++; $display("FAIL err_prio got=%b exp=1110001000", {ifc.bus_drv, ifc.bus_out, ifc.bus_err}); end
        tick();
        vectors++; if (ifc.bus_err !== 1'b1) begin miscompares++; $display("FAIL err_set got=%b exp=1", ifc.bus_err); end
        idle(); ifc.prog_mode = 1; tick();
        idle(); tick();
        vectors++; if (ifc.bus_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got=%b exp=1", ifc.bus_err); end
        hard_reset();
        vectors++; if (ifc.bus_err !== 1'b0) begin miscompares++; $display("FAIL err_clr got=%b exp=0", ifc.bus_err); end
    endtask

    task automatic test_clr_mid();
        logic [7:0] d;
        hard_reset();
        prog_write(4'h0, 8'h27);
        prog_write(4'h7, 8'h66);
        prog_write(4'h5, 8'h11);
        ifc.ep = 1; ifc.lm = 1; tick();
        idle(); ifc.cp = 1; tick();
        idle(); ifc.ce = 1; ifc.li = 1; tick();
        idle(); ifc.ei = 1; ifc.lm = 1;
        #2;
        clr = 0;
        #1;
        vectors++; if ({ifc.pc, ifc.mar, ifc.ireg} !== 12'h000) begin miscompares++; $display("FAIL clr_async got=%h exp=000", {ifc.pc, ifc.mar, ifc.ireg}); end
        idle(); ifc.prog_mode = 1; ifc.prog_we = 1; ifc.prog_addr = 4'h5; ifc.prog_data = 8'hAA;
        tick();
        idle();
        clr = 1;
        read_ram(4'h5, d);
        vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL clr_write_blocked got=%h exp=11", d); end
        read_ram(4'h7, d);
        vectors++; if (d !== 8'h66) begin miscompares++; $display("FAIL clr_ram7 got=%h exp=66", d); end
        read_ram(4'h0, d);
        vectors++; if (d !== 8'h27) begin miscompares++; $display("FAIL clr_ram0 got=%h exp=27", d); end
    endtask

    task automatic test_ext_load();
        hard_reset();
        ifc.bus_in = 8'h3B; ifc.li = 1;
        #1;
        vectors++; if (ifc.bus_drv !== 1'b0) begin miscompares++; $display("FAIL ext_nodrv got=%b exp=0", ifc.bus_drv); end
        tick();
        vectors++; if (ifc.ireg !== 4'h3) begin miscompares++; $display("FAIL ext_ireg got=%h exp=3", ifc.ireg); end
        idle(); ifc.ei = 1;
        #1;
        vectors++; if (ifc.bus_out !== 8'h0B) begin miscompares++; $display("FAIL ext_operand got=%h exp=0b", ifc.bus_out); end
        hard_reset();
        ifc.prog_mode = 1; ifc.bus_in = 8'h3B; ifc.li = 1;
        tick();
        vectors++; if (ifc.ireg !== 4'h0) begin miscompares++; $display("FAIL ext_prog_ignored got=%h exp=0", ifc.ireg); end
        idle(); ifc.ei = 1;
        #1;
        vectors++; if (ifc.bus_out !== 8'h00) begin miscompares++; $display("FAIL ext_prog_ir got=%h exp=00", ifc.bus_out); end
        idle();
    endtask

    task automatic test_random();
        logic       run, edrv;
        logic [7:0] eout, bv;
        hard_reset();
        for (int a = 0; a < 16; a++) prog_write(4'(a), 8'($urandom));
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) hard_reset();
            ifc.prog_mode = ($urandom_range(0, 9) == 0);
            ifc.prog_we   = $urandom_range(0, 1);
            ifc.prog_addr = 4'($urandom);
            ifc.prog_data = 8'($urandom);
            ifc.bus_in    = 8'($urandom);
            ifc.cp = ($urandom_range(0, 2) == 0);
            ifc.ep = ($urandom_range(0, 3) == 0);
            ifc.lm = ($urandom_range(0, 2) == 0);
            ifc.ce = ($urandom_range(0, 3) == 0);
            ifc.li = ($urandom_range(0, 2) == 0);
            ifc.ei = ($urandom_range(0, 3) == 0);
            // model: who owns the bus right now
            run  = !ifc.prog_mode && !m_halt;
            edrv = run && (ifc.ep || ifc.ce || ifc.ei);
            eout = 8'h00;
            if (edrv) eout = ifc.ce ? m_mem[m_mar] : ifc.ei ? {4'h0, m_ir[3:0]} : {4'h0, m_pc};
            #1;
            vectors++; if ({ifc.bus_drv, ifc.bus_out} !== {edrv, eout}) begin miscompares++; $display("FAIL rand_bus n=%0d got=%h exp=%h", n, {ifc.bus_drv, ifc.bus_out}, {edrv, eout}); end
            bv = edrv ? eout : ifc.bus_in;
            // model: effect of the coming clock edge
            if (ifc.prog_mode) begin
                m_pc = 0; m_mar = 0; m_ir = 0; m_halt = 0;
                if (ifc.prog_we) m_mem[ifc.prog_addr] = ifc.prog_data;
            end else if (run) begin
                if (m_ir[7:4] == 4'hF) m_halt = 1;
                if ((int'(ifc.ep) + int'(ifc.ce) + int'(ifc.ei)) >= 2) m_err = 1;
                if (ifc.cp) m_pc = (m_pc + 1) % 16;
                if (ifc.lm) m_mar = bv[3:0];
                if (ifc.li) m_ir = bv;
            end
            tick();
            vectors++; if ({ifc.pc, ifc.mar, ifc.ireg, ifc.halt, ifc.bus_err} !== {m_pc, m_mar, m_ir[7:4], m_halt, m_err}) begin miscompares++; $display("FAIL rand_state n=%0d got=%h exp=%h", n, {ifc.pc, ifc.mar, ifc.ireg, ifc.halt, ifc.bus_err}, {m_pc, m_mar, m_ir[7:4], m_halt, m_err}); end
        end
        idle();
    endtask

    initial begin
        clr = 0;
        test_reset();
        test_fetch();
        test_pc_wrap();
        test_halt();
        test_bus_err();
        test_clr_mid();
        test_ext_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
